// File: rtl/rx_byte_assembler.sv
// Byte assembler for the ISO 14443A receive path: groups decoded bits into
// LSB-first bytes, checks/strips odd parity and reports partial last bytes.
module rx_byte_assembler #(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_error,
  input  logic       in_data_valid,
  input  logic       in_data,
  output logic       out_soc,
  output logic       out_eoc,
  output logic       out_error,
  output logic       out_data_valid,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits
);

  typedef enum logic [1:0] {IDLE, RX, DROP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        soc_nxt, eoc_nxt, error_nxt, dv_nxt;
  logic [7:0]  data_nxt;
  logic [2:0]  bits_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      shift          <= 8'd0;
      out_soc        <= 1'b0;
      out_eoc        <= 1'b0;
      out_error      <= 1'b0;
      out_data_valid <= 1'b0;
      out_data       <= 8'd0;
      out_data_bits  <= 3'd0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      shift          <= shift_nxt;
      out_soc        <= soc_nxt;
      out_eoc        <= eoc_nxt;
      out_error      <= error_nxt;
      out_data_valid <= dv_nxt;
      out_data       <= data_nxt;
      out_data_bits  <= bits_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    soc_nxt   = 1'b0;
    eoc_nxt   = 1'b0;
    error_nxt = 1'b0;
    dv_nxt    = 1'b0;
    data_nxt  = out_data;
    bits_nxt  = out_data_bits;

    if (in_soc) begin
      soc_nxt   = 1'b1;
      cnt_nxt   = 4'd0;
      shift_nxt = 8'd0;
      state_nxt = RX;
    end else begin
      case (state)
        RX: begin
          if (in_error) begin
            error_nxt = 1'b1;
            state_nxt = DROP;
          end else if (in_eoc) begin
            eoc_nxt   = 1'b1;
            if (cnt == 4'd8) begin
              error_nxt = 1'b1;
            end else if (cnt != 4'd0) begin
              dv_nxt   = 1'b1;
              data_nxt = shift;
              bits_nxt = cnt[2:0];
            end
            cnt_nxt   = 4'd0;
            shift_nxt = 8'd0;
            state_nxt = IDLE;
          end else if (in_data_valid) begin
            // Shift is cleared at every byte boundary so a partial last
            // byte always reports its unused upper bits as zero.
            if (CHECK_PARITY && cnt == 4'd8) begin
              if ((^shift) ^ in_data) begin
                dv_nxt   = 1'b1;
                data_nxt = shift;
                bits_nxt = 3'd0;
              end else begin
                error_nxt = 1'b1;
                state_nxt = DROP;
              end
              cnt_nxt   = 4'd0;
              shift_nxt = 8'd0;
            end else if (!CHECK_PARITY && cnt == 4'd7) begin
              dv_nxt    = 1'b1;
              data_nxt  = {in_data, shift[6:0]};
              bits_nxt  = 3'd0;
              cnt_nxt   = 4'd0;
              shift_nxt = 8'd0;
            end else begin
              shift_nxt[cnt[2:0]] = in_data;
              cnt_nxt             = cnt + 4'd1;
            end
          end
        end
        DROP: begin
          if (in_eoc) state_nxt = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: one instance with parity checking,
// one without, both driven from the same stimulus.
module tb_rx_byte_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_soc = 1'b0, in_eoc = 1'b0, in_error = 1'b0;
  logic in_data_valid = 1'b0, in_data = 1'b0;

  logic       soc1, eoc1, err1, dv1;
  logic [7:0] data1;
  logic [2:0] bits1;
  logic       soc0, eoc0, err0, dv0;
  logic [7:0] data0;
  logic [2:0] bits0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_byte_assembler #(.CHECK_PARITY(1'b1)) dut_par (
    .clk(clk), .rst_n(rst_n),
    .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
    .in_data_valid(in_data_valid), .in_data(in_data),
    .out_soc(soc1), .out_eoc(eoc1), .out_error(err1),
    .out_data_valid(dv1), .out_data(data1), .out_data_bits(bits1)
  );

  rx_byte_assembler #(.CHECK_PARITY(1'b0)) dut_nopar (
    .clk(clk), .rst_n(rst_n),
    .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
    .in_data_valid(in_data_valid), .in_data(in_data),
    .out_soc(soc0), .out_eoc(eoc0), .out_error(err0),
    .out_data_valid(dv0), .out_data(data0), .out_data_bits(bits0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flags order: {soc, eoc, error, data_valid}; data/bits checked only with data_valid.
  task automatic expect_out(input string tag, input int sel, input logic [3:0] f,
                            input logic [7:0] d, input logic [2:0] b);
    if (sel == 1) begin
      check(tag, {28'd0, soc1, eoc1, err1, dv1}, {28'd0, f});
      if (f[0]) begin
        check({tag, ".data"}, {24'd0, data1}, {24'd0, d});
        check({tag, ".bits"}, {29'd0, bits1}, {29'd0, b});
      end
    end else begin
      check(tag, {28'd0, soc0, eoc0, err0, dv0}, {28'd0, f});
      if (f[0]) begin
        check({tag, ".data"}, {24'd0, data0}, {24'd0, d});
        check({tag, ".bits"}, {29'd0, bits0}, {29'd0, b});
      end
    end
  endtask

  task automatic cyc(input logic s, input logic e, input logic r, input logic v, input logic b);
    in_soc = s; in_eoc = e; in_error = r; in_data_valid = v; in_data = b;
    @(posedge clk);
    #1;
    in_soc = 1'b0; in_eoc = 1'b0; in_error = 1'b0; in_data_valid = 1'b0; in_data = 1'b0;
  endtask

  // Sends n bits LSB first; all but the last must be silent, the caller checks the last.
  task automatic send_bits(input string tag, input int sel, input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, v[i]);
      if (i < n - 1) expect_out(tag, sel, 4'b0000, 8'h00, 3'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset.flags1", {28'd0, soc1, eoc1, err1, dv1}, 32'd0);
    check("reset.data1", {21'd0, data1, bits1}, 32'd0);
    check("reset.flags0", {28'd0, soc0, eoc0, err0, dv0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Standard frame with parity
    cyc(1, 0, 0, 0, 0);            expect_out("std.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("std.b0", 1, {1'b1, 8'h93}, 9); expect_out("std.byte0", 1, 4'b0001, 8'h93, 3'd0);
    send_bits("std.b1", 1, {1'b0, 8'h20}, 9); expect_out("std.byte1", 1, 4'b0001, 8'h20, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("std.eoc", 1, 4'b0100, 8'h00, 3'd0);
    cyc(0, 0, 0, 0, 0);            expect_out("std.quiet", 1, 4'b0000, 8'h00, 3'd0);

    // Short 7-bit frame
    cyc(1, 0, 0, 0, 0);            expect_out("short.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("short.b", 1, 9'h026, 7); expect_out("short.last", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("short.eoc", 1, 4'b0101, 8'h26, 3'd7);

    // Parity error then DROP
    cyc(1, 0, 0, 0, 0);            expect_out("perr.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("perr.b0", 1, {1'b0, 8'h93}, 9); expect_out("perr.err", 1, 4'b0010, 8'h00, 3'd0);
    send_bits("perr.b1", 1, {1'b0, 8'h20}, 9); expect_out("perr.drop", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("perr.eoc", 1, 4'b0000, 8'h00, 3'd0);

    // Missing parity bit
    cyc(1, 0, 0, 0, 0);            expect_out("mpar.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("mpar.b", 1, 9'h0FF, 8); expect_out("mpar.last", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("mpar.eoc", 1, 4'b0110, 8'h00, 3'd0);

    // Decoder error after 3 bits, later eoc silent
    cyc(1, 0, 0, 0, 0);            expect_out("derr.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("derr.b", 1, 9'h005, 3); expect_out("derr.last", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 0, 1, 0, 0);            expect_out("derr.err", 1, 4'b0010, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("derr.eoc", 1, 4'b0000, 8'h00, 3'd0);

    // error beats eoc in the same cycle
    cyc(1, 0, 0, 0, 0);            expect_out("prio.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("prio.b", 1, 9'h003, 2); expect_out("prio.last", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 1, 0, 0);            expect_out("prio.err", 1, 4'b0010, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("prio.eoc", 1, 4'b0000, 8'h00, 3'd0);

    // Restart mid-byte
    cyc(1, 0, 0, 0, 0);            expect_out("rst.soc0", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("rst.pre", 1, 9'h005, 3); expect_out("rst.pre3", 1, 4'b0000, 8'h00, 3'd0);
    cyc(1, 0, 0, 0, 0);            expect_out("rst.soc1", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("rst.b", 1, 9'h052, 7); expect_out("rst.last", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("rst.eoc", 1, 4'b0101, 8'h52, 3'd7);

    // Asynchronous reset mid-byte
    cyc(1, 0, 0, 0, 0);            expect_out("arst.soc", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("arst.b0", 1, {1'b1, 8'h93}, 9); expect_out("arst.byte", 1, 4'b0001, 8'h93, 3'd0);
    send_bits("arst.b1", 1, 9'h007, 3);
    check("arst.held", {24'd0, data1}, 32'h93);
    #1 rst_n = 1'b0;
    #1;
    check("arst.data", {21'd0, data1, bits1}, 32'd0);
    check("arst.flags", {28'd0, soc1, eoc1, err1, dv1}, 32'd0);
    rst_n = 1'b1;
    send_bits("arst.idle", 1, 9'h007, 3); expect_out("arst.idle3", 1, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("arst.idle_eoc", 1, 4'b0000, 8'h00, 3'd0);
    cyc(1, 0, 0, 0, 0);            expect_out("arst.soc2", 1, 4'b1000, 8'h00, 3'd0);
    send_bits("arst.sb", 1, 9'h026, 7);
    cyc(0, 1, 0, 0, 0);            expect_out("arst.eoc2", 1, 4'b0101, 8'h26, 3'd7);

    // No-parity instance
    cyc(1, 0, 0, 0, 0);            expect_out("np.soc", 0, 4'b1000, 8'h00, 3'd0);
    send_bits("np.b0", 0, 9'h093, 8); expect_out("np.byte0", 0, 4'b0001, 8'h93, 3'd0);
    send_bits("np.b1", 0, 9'h020, 8); expect_out("np.byte1", 0, 4'b0001, 8'h20, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("np.eoc", 0, 4'b0100, 8'h00, 3'd0);
    cyc(1, 0, 0, 1, 1);            expect_out("np.socdv", 0, 4'b1000, 8'h00, 3'd0);
    send_bits("np.sb", 0, 9'h026, 7); expect_out("np.sb_last", 0, 4'b0000, 8'h00, 3'd0);
    cyc(0, 1, 0, 0, 0);            expect_out("np.eoc2", 0, 4'b0101, 8'h26, 3'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_byte_assembler.md
# rx_byte_assembler

Assembles the bit-level event stream from the ISO/IEC 14443A frame decoder into the byte-level rx_interface event stream consumed by the initiator-to-target protocol layers. Groups bits into LSB-first bytes, checks and strips odd parity, and reports partial last bytes on EOC. Errors are reported as single-cycle events. It is the producing end of the byte-mode rx_interface (soc/eoc/error/data_valid/data/data_bits) and sits between frame_decode and the ISO 14443-3/4 logic.

## Interface

- CHECK_PARITY, 1, 1: every 9th bit of a frame is an odd-parity bit, checked and stripped. 0: no parity; bytes are 8 bits.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_soc  in  1  start of frame pulse
- in_eoc  in  1  end of frame pulse
- in_error  in  1  decoder error pulse
- in_data_valid  in  1  in_data holds a valid bit this cycle
- in_data  in  1  received bit; first bit of a frame is the byte LSB
- out_soc  out  1  start of frame event
- out_eoc  out  1  end of frame event
- out_error  out  1  error event
- out_data_valid  out  1  out_data and out_data_bits are valid
- out_data  out  8  assembled byte, LSB = first received bit
- out_data_bits  out  3  0 = full byte; 1..7 = bits valid in a partial last byte

## Operation

- States: IDLE, RX, DROP. Reset enters IDLE.
- Input priority within one cycle: soc > error > eoc > data_valid. Lower-priority flags in the same cycle are discarded.
- in_soc in any state:
  - emits out_soc
  - clears the bit counter and shift register
  - goes to RX, discarding any partial data
- IDLE: in_error, in_eoc and in_data_valid are ignored; no output.
- RX, in_data_valid:
  - bit index n (0-based within the current group) is written to shift[n]; the counter increments.
  - CHECK_PARITY=1, n=8: the bit is parity. If shift XOR-reduced XOR bit == 1, emit data_valid with data=shift and data_bits=0. Otherwise emit out_error and go to DROP. The counter wraps to 0 in both cases.
  - CHECK_PARITY=0, n=7: emit data_valid with data={bit, shift[6:0]} and data_bits=0; the counter wraps to 0.
- RX, in_eoc, by count c:
  - c=0: emit out_eoc alone.
  - c=1..7: emit out_eoc + out_data_valid, data_bits=c, data=shift. Bits c..7 are 0.
  - c=8 (parity bit missing, CHECK_PARITY=1 only): emit out_eoc + out_error, no data.
  - Then go to IDLE.
- RX, in_error: emit out_error, go to DROP.
- DROP: ignores everything except in_soc; in_eoc produces no output and returns to IDLE.
- Only these combinations are ever emitted: soc alone; data_valid alone; error alone; eoc alone; eoc+error; eoc+data_valid.

## Timing

- All outputs are registered; latency is exactly 1 clk from the input event.
- Every out_* flag is a single-cycle pulse. Back-to-back input events give back-to-back outputs; there is no backpressure.
- out_data and out_data_bits are held from the last data_valid output and are don't-care when out_data_valid=0.
- rst_n asserted (asynchronous, including mid-frame): all flags 0, out_data=0, out_data_bits=0, counter 0, state IDLE. The first event after release must be in_soc to produce output.
- The bit counter is 4 bits and never exceeds 8.

## Test plan

- Standard frame, CHECK_PARITY=1: soc, then bits of 0x93 + parity 1, then 0x20 + parity 0, then eoc. Required output: soc; data 0x93 with bits 0; data 0x20 with bits 0; eoc alone. Each event appears 1 cycle after its input.
- Short frame: soc, then 7 bits of 0x26 LSB first, then eoc. Required output: soc; eoc+data_valid with data_bits=7 and data=0x26.
- Parity error: soc, 0x93 with parity 0, then bits of 0x20, then eoc. Required output: soc; error. Nothing follows (DROP), and the next soc is accepted normally.
- Missing parity: soc, 8 bits 0xFF, eoc. Required output: soc; eoc+error. Decoder error after 3 bits: soc; error, and the later eoc is silent.
- Restart and reset: soc, 3 bits, soc, full frame 0x52 (REQA-style, 7 bits) → soc, soc, eoc+data_valid with bits=7 and data=0x52. Separately, rst_n pulsed mid-byte → all outputs 0 immediately; in_data_valid before any soc gives no output.
- CHECK_PARITY=0: soc, 16 bits (0x93, 0x20), eoc → data 0x93 emitted 1 cycle after the 8th bit, data 0x20 after the 16th, then eoc alone. Simultaneous in_soc+in_data_valid gives soc only.
